hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline hazard and forwarding controller for the 19-bit five-stage core: IF, ID, EX, MEM, WB.
- Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB control fields, decoded from the instruction leaving ID.
- Detects load-use and flag-use hazards and stalls for them.
- Drives the EX operand forwarding selects.
- Flushes IF/ID when ID redirects the PC.
- Sits beside the ID-stage decode controller and drives the pipeline-register enables.

Parameters:
REG_ADDR_W, 3, register-address width (8 registers, all writable)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_instr  input  19  instruction currently in ID
id_valid  input  1  ID holds a real instruction (0 = bubble)
pc_redirect  input  1  ID decode selects a non-sequential PC (taken branch, JMP, JSB, RET)
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID register enable
flush_if_id  output  1  IF/ID register loads a bubble
id_ex_bubble  output  1  ID/EX register loads a bubble
fwd_a  output  2  EX operand A select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
fwd_b  output  2  EX operand B select, same encoding
stall_count  output  CNT_W  number of stall cycles, saturating

Behaviour:
Interface: single clock clk; reset is asynchronous and active-high.

Decode of id_instr. Fields: op = [18:16], rd = [13:11], rs = [10:8], rt = [7:5]. Only when id_valid=1.
- op 00x (arith reg): reads rs and rt; writes rd; sets flags.
- op 01x (arith imm): reads rs; writes rd; sets flags.
- op 100, bit14=0 (LDM): reads rs; writes rd; is_load.
- op 100, bit14=1 (STM): reads rs (source A) and rd (source B); no write.
- op 110 (shift): reads rs; writes rd; sets flags.
- op 101 (branch): uses_flags; no register reads or writes.
- op 111 (JMP/JSB/RET): no register reads, writes or flag use.

Shadow stage record: {valid, wr, ld, sf, rd, a_used, a, b_used, b}.
- Three records: IDEX, EXMEM, MEMWB.
- Reset: all valid=0, stall_count=0.

Hazards, combinational from the ID decode and IDEX:
- load_use = IDEX.valid & IDEX.ld & ((ID reads rs & rs==IDEX.rd) | (ID reads B & B==IDEX.rd)).
- flag_use = ID uses_flags & IDEX.valid & IDEX.sf. Branch conditions use C/Z, which are written at the end of EX.
- stall = load_use | flag_use.

Enables and flush:
- pc_write = if_id_write = ~stall.
- id_ex_bubble = stall.
- flush_if_id = pc_redirect & ~stall. While stalled, a redirect is ignored and is re-evaluated next cycle.

Clock edge:
- IDEX <= stall ? bubble : decode(id_instr).
- EXMEM <= IDEX; MEMWB <= EXMEM. These always advance.
- stall_count increments when stall=1 and saturates at all-ones.

Forwarding, combinational from the records:
- fwd_a = 01 if IDEX.a_used & EXMEM.valid & EXMEM.wr & EXMEM.rd==IDEX.a.
- Else fwd_a = 10 if IDEX.a_used & MEMWB.valid & MEMWB.wr & MEMWB.rd==IDEX.a.
- Else fwd_a = 00.
- fwd_b uses the same rules with b. EX/MEM has priority over MEM/WB.
- Invalid records never match. Encoding 11 is never driven.

Reset: while reset=1 and after release, pc_write=1, if_id_write=1, flush_if_id=0 (pc_redirect is ignored while reset=1), id_ex_bubble=0, fwd_a=fwd_b=00, stall_count=0. A reset mid-stall clears the stall immediately.

Latency:
- Stall is exactly 1 cycle per hazard. A hazard recurs only if the same condition holds again.
- Hazard outputs are combinational from registered state plus the ID inputs.

Test Plan:
- Each op class in ID, with id_valid=1 and no prior writers → stall=0, fwd_a=fwd_b=00, pc_write=1.
- ADD R1 (arith reg, rd=1) then ADD rd=2 rs=1 rt=1 on consecutive cycles → no stall; the second instruction in EX sees fwd_a=fwd_b=01. With one unrelated instruction between them → 10.
- LDM rd=3 then ADD rs=3 → stall=1 for one cycle, id_ex_bubble=1, stall_count=1. The next cycle the ADD is in EX with fwd_a=10. The same test with STM reading rd=3 as source B → stall, then fwd_b=10.
- Shift then branch in ID → one stall cycle. Branch with pc_redirect=1 during the stall → flush_if_id=0. The next cycle → flush_if_id=1.
- JMP with pc_redirect=1 and no hazard → flush_if_id=1, pc_write=1. With id_valid=0 → no record is written and no forwarding matches later.
- Reset asserted mid-stall → outputs take their reset values asynchronously. Force 2^CNT_W+3 hazard cycles → stall_count holds all-ones.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and forwarding controller for the 19-bit five-stage core.
// Decodes the instruction leaving ID into a shadow record. The record then
// moves through ID/EX, EX/MEM and MEM/WB copies. These copies drive the
// load-use and flag-use stalls, the EX operand forwarding selects, the
// pipeline-register enables and the IF/ID flush.
module hazard_controller #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [18:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  pc_redirect,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  flush_if_id,
  output logic                  id_ex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count
);

  // Shadow copy of the control fields that one pipeline stage carries.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  ld;
    logic                  sf;
    logic [REG_ADDR_W-1:0] rd;
    logic                  a_used;
    logic [REG_ADDR_W-1:0] a;
    logic                  b_used;
    logic [REG_ADDR_W-1:0] b;
  } stage_rec_t;

  // Forwarding select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Major opcode values in id_instr[18:16]
  localparam logic [2:0] OP_ARITH_R0 = 3'b000;
  localparam logic [2:0] OP_ARITH_R1 = 3'b001;
  localparam logic [2:0] OP_ARITH_I0 = 3'b010;
  localparam logic [2:0] OP_ARITH_I1 = 3'b011;
  localparam logic [2:0] OP_MEM      = 3'b100;
  localparam logic [2:0] OP_BRANCH   = 3'b101;
  localparam logic [2:0] OP_SHIFT    = 3'b110;
  localparam logic [2:0] OP_JUMP     = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Instruction fields
  logic [2:0]            id_op;
  logic                  id_store_sel;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;

  // Decode results for the instruction in ID
  stage_rec_t dec_rec;
  logic       dec_uses_flags;

  // Hazard terms
  logic load_use_a;
  logic load_use_b;
  logic load_use;
  logic flag_use;
  logic stall;

  // Shadow records and stall counter
  stage_rec_t       idex_q,  idex_d;
  stage_rec_t       exmem_q, exmem_d;
  stage_rec_t       memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Choose the forwarding source for one EX operand. EX/MEM wins over MEM/WB.
  // Invalid records cannot match because valid is checked.
  function automatic logic [1:0] fwd_select(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input stage_rec_t            em,
    input stage_rec_t            mw
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && em.valid && em.wr && (em.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (used && mw.valid && mw.wr && (mw.rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  assign id_op        = id_instr[18:16];
  assign id_store_sel = id_instr[14];
  assign id_rd        = id_instr[11 +: REG_ADDR_W];
  assign id_rs        = id_instr[8 +: REG_ADDR_W];
  assign id_rt        = id_instr[5 +: REG_ADDR_W];

  // Decode ID into a stage record; a bubble in ID gives an all-zero record.
  always_comb begin
    dec_rec        = '0;
    dec_uses_flags = 1'b0;
    if (id_valid) begin
      dec_rec.valid = 1'b1;
      case (id_op)
        OP_ARITH_R0, OP_ARITH_R1: begin
          dec_rec.a_used = 1'b1;
          dec_rec.a      = id_rs;
          dec_rec.b_used = 1'b1;
          dec_rec.b      = id_rt;
          dec_rec.wr     = 1'b1;
          dec_rec.rd     = id_rd;
          dec_rec.sf     = 1'b1;
        end
        OP_ARITH_I0, OP_ARITH_I1, OP_SHIFT: begin
          dec_rec.a_used = 1'b1;
          dec_rec.a      = id_rs;
          dec_rec.wr     = 1'b1;
          dec_rec.rd     = id_rd;
          dec_rec.sf     = 1'b1;
        end
        OP_MEM: begin
          dec_rec.a_used = 1'b1;
          dec_rec.a      = id_rs;
          if (id_store_sel) begin
            // STM: rd is the store-data source, nothing is written back
            dec_rec.b_used = 1'b1;
            dec_rec.b      = id_rd;
          end else begin
            dec_rec.wr = 1'b1;
            dec_rec.rd = id_rd;
            dec_rec.ld = 1'b1;
          end
        end
        OP_BRANCH: begin
          dec_uses_flags = 1'b1;
        end
        OP_JUMP: begin
          dec_rec.valid = 1'b1;
        end
        default: begin
          dec_rec.valid = 1'b1;
        end
      endcase
    end
  end

  // Detect load-use and flag-use hazards between ID and the record in ID/EX.
  always_comb begin
    load_use_a = dec_rec.a_used && (dec_rec.a == idex_q.rd);
    load_use_b = dec_rec.b_used && (dec_rec.b == idex_q.rd);
    load_use   = idex_q.valid && idex_q.ld && (load_use_a || load_use_b);
    // C/Z become valid only at the end of EX, so a branch right behind a setter waits
    flag_use   = dec_uses_flags && idex_q.valid && idex_q.sf;
    stall      = load_use || flag_use;
  end

  // Drive pipeline enables and flush. A redirect is held off while stalled.
  always_comb begin
    pc_write     = ~stall;
    if_id_write  = ~stall;
    id_ex_bubble = stall;
    flush_if_id  = pc_redirect && !stall && !reset;
  end

  // Drive the EX operand forwarding selects from the shadow records.
  always_comb begin
    fwd_a = fwd_select(idex_q.a_used, idex_q.a, exmem_q, memwb_q);
    fwd_b = fwd_select(idex_q.b_used, idex_q.b, exmem_q, memwb_q);
  end

  // Next state: advance the records and count stall cycles up to saturation.
  always_comb begin
    idex_d        = stall ? '0 : dec_rec;
    exmem_d       = idex_q;
    memwb_d       = exmem_q;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State registers. The asynchronous reset clears all records.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q        <= '0;
      exmem_q       <= '0;
      memwb_q       <= '0;
      stall_count_q <= '0;
    end else begin
      idex_q        <= idex_d;
      exmem_q       <= exmem_d;
      memwb_q       <= memwb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller. Each step pushes the expected
// outputs to a scoreboard. The outputs are then popped and compared mid-cycle.
module tb_hazard_controller;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                reset;
  logic [18:0]         id_instr;
  logic                id_valid;
  logic                pc_redirect;
  logic                pc_write;
  logic                if_id_write;
  logic                flush_if_id;
  logic                id_ex_bubble;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic [TB_CNT_W-1:0] stall_count;

  typedef struct packed {
    logic                pc_write;
    logic                if_id_write;
    logic                flush;
    logic                bubble;
    logic [1:0]          fa;
    logic [1:0]          fb;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t                exp_q[$];
  string               tag_q[$];
  logic [TB_CNT_W-1:0] exp_cnt;
  int                  errors;
  int                  checks;

  hazard_controller #(.REG_ADDR_W(3), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .pc_redirect  (pc_redirect),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .flush_if_id  (flush_if_id),
    .id_ex_bubble (id_ex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [2:0] op, input logic b14,
                                     input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [2:0] rt);
    return {op, 1'b0, b14, rd, rs, rt, 5'b00000};
  endfunction

  task automatic checkField(input string tag, input string name,
                            input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      checkField(tag, "pc_write",     16'(pc_write),     16'(e.pc_write));
      checkField(tag, "if_id_write",  16'(if_id_write),  16'(e.if_id_write));
      checkField(tag, "flush_if_id",  16'(flush_if_id),  16'(e.flush));
      checkField(tag, "id_ex_bubble", 16'(id_ex_bubble), 16'(e.bubble));
      checkField(tag, "fwd_a",        16'(fwd_a),        16'(e.fa));
      checkField(tag, "fwd_b",        16'(fwd_b),        16'(e.fb));
      checkField(tag, "stall_count",  16'(stall_count),  16'(e.cnt));
    end
  endtask

  // Queue one cycle's expectation. The counter shows its pre-edge value.
  task automatic pushExpect(input string tag, input logic s, input logic fl,
                            input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    e.pc_write    = ~s;
    e.if_id_write = ~s;
    e.flush       = fl;
    e.bubble      = s;
    e.fa          = ea;
    e.fb          = eb;
    e.cnt         = exp_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (s && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic expectReset(input string tag);
    exp_cnt = '0;
    pushExpect(tag, 1'b0, 1'b0, 2'b00, 2'b00);
    checkOutput();
  endtask

  // One cycle: drive just after posedge, check at negedge, move to next posedge.
  task automatic applyStimulus(input string tag, input logic [18:0] instr,
                               input logic v, input logic redir, input logic s,
                               input logic fl, input logic [1:0] ea,
                               input logic [1:0] eb);
    id_instr    = instr;
    id_valid    = v;
    pc_redirect = redir;
    pushExpect(tag, s, fl, ea, eb);
    #4;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("drain", 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    exp_cnt     = '0;
    reset       = 1'b1;
    id_instr    = 19'd0;
    id_valid    = 1'b0;
    pc_redirect = 1'b1;
    #2;
    expectReset("reset_active");
    @(posedge clk);
    #1;
    expectReset("reset_after_edge");
    reset       = 1'b0;
    pc_redirect = 1'b0;
    applyStimulus("post_release", 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // Every op class with no earlier writers of its sources
    applyStimulus("cls_arith_reg", mk(3'b000, 1'b0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_arith_imm", mk(3'b010, 1'b0, 3'd4, 3'd5, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_ldm",       mk(3'b100, 1'b0, 3'd6, 3'd7, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_stm",       mk(3'b100, 1'b1, 3'd0, 3'd2, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_jmp",       mk(3'b111, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_branch",    mk(3'b101, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("cls_shift",     mk(3'b110, 1'b0, 3'd5, 3'd3, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();

    // Back-to-back dependency forwards from EX/MEM
    applyStimulus("fwd1_add_r1", mk(3'b000, 1'b0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fwd1_add_r2", mk(3'b000, 1'b0, 3'd2, 3'd1, 3'd1), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fwd1_in_ex",  19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    drain();

    // One unrelated instruction between forwards from MEM/WB
    applyStimulus("fwd2_add_r1", mk(3'b000, 1'b0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fwd2_other",  mk(3'b010, 1'b0, 3'd6, 3'd7, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fwd2_add_r2", mk(3'b000, 1'b0, 3'd2, 3'd1, 3'd1), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fwd2_in_ex",  19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
    drain();

    // Both later stages write r1: EX/MEM has priority
    applyStimulus("prio_w1",    mk(3'b000, 1'b0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("prio_w2",    mk(3'b000, 1'b0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("prio_use",   mk(3'b000, 1'b0, 3'd2, 3'd1, 3'd1), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("prio_in_ex", 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    drain();

    // Load-use on source A
    applyStimulus("lu_ldm",      mk(3'b100, 1'b0, 3'd3, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lu_add_stall", mk(3'b000, 1'b0, 3'd4, 3'd3, 3'd5), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    applyStimulus("lu_add_go",   mk(3'b000, 1'b0, 3'd4, 3'd3, 3'd5), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lu_in_ex",    19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    drain();

    // Load-use on STM store-data source B
    applyStimulus("lus_ldm",     mk(3'b100, 1'b0, 3'd3, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lus_stm_stall", mk(3'b100, 1'b1, 3'd3, 3'd6, 3'd0), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    applyStimulus("lus_stm_go",  mk(3'b100, 1'b1, 3'd3, 3'd6, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lus_in_ex",   19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    drain();

    // Load-use on arith rt
    applyStimulus("lut_ldm",      mk(3'b100, 1'b0, 3'd3, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lut_add_stall", mk(3'b000, 1'b0, 3'd4, 3'd5, 3'd3), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    applyStimulus("lut_add_go",   mk(3'b000, 1'b0, 3'd4, 3'd5, 3'd3), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("lut_in_ex",    19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    drain();

    // Flag-use: a redirect is held during the stall and flushes next cycle
    applyStimulus("fu_shift",        mk(3'b110, 1'b0, 3'd5, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("fu_branch_stall", mk(3'b101, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    applyStimulus("fu_branch_go",    mk(3'b101, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    drain();

    // JMP redirect, then a bubble whose bits look like a writer of r1
    applyStimulus("jmp_redirect", mk(3'b111, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    applyStimulus("inv_add_r1",   mk(3'b000, 1'b0, 3'd1, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("inv_use_r1",   mk(3'b000, 1'b0, 3'd2, 3'd1, 3'd1), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("inv_in_ex",    19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("inv_ldm_r3",   mk(3'b100, 1'b0, 3'd3, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus("inv_ldm_use",  mk(3'b000, 1'b0, 3'd4, 3'd3, 3'd5), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    drain();

    // Asynchronous reset in the middle of a load-use stall
    applyStimulus("rst_ldm", mk(3'b100, 1'b0, 3'd3, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    id_instr    = mk(3'b000, 1'b0, 3'd4, 3'd3, 3'd5);
    id_valid    = 1'b1;
    pc_redirect = 1'b0;
    pushExpect("rst_stall", 1'b1, 1'b0, 2'b00, 2'b00);
    #4;
    checkOutput();
    #1;
    reset       = 1'b1;
    pc_redirect = 1'b1;
    #1;
    expectReset("rst_mid_stall");
    @(posedge clk);
    #1;
    expectReset("rst_hold_edge");
    reset       = 1'b0;
    pc_redirect = 1'b0;
    applyStimulus("rst_released", mk(3'b000, 1'b0, 3'd4, 3'd3, 3'd5), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // 2^CNT_W+3 flag-use stalls: the counter holds at all-ones
    for (int i = 0; i < (1 << TB_CNT_W) + 3; i++) begin
      applyStimulus("sat_shift",  mk(3'b110, 1'b0, 3'd5, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      applyStimulus("sat_branch", mk(3'b101, 1'b0, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    end
    applyStimulus("sat_final", 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
